// File: rtl/rf_2r_2w_bypass_if.sv
// ---------------------------------------------------------------------------
// rf_2r_2w_bypass_if
//   Bus bundle for the 2-read / 2-write register file.
//   master : the client that drives writes, reads and clear, and consumes the
//            registered read data, valid flags and the conflict counter.
//   slave  : the register file itself.
// Signals
//   clear_i                              invalidate and zero all entries
//   write1_en_i/write1_addr_i/data1_i    write port 1 (priority port)
//   write2_en_i/write2_addr_i/data2_i    write port 2
//   read1_en_i/read1_addr_i              read port 1 request
//   read2_en_i/read2_addr_i              read port 2 request
//   data1_o/valid1_o, data2_o/valid2_o   registered read results
//   conflict_cnt_o                       saturating count of dropped port-2 writes
// ---------------------------------------------------------------------------
interface rf_2r_2w_bypass_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 8
) ();
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  clear_i;
  logic                  write1_en_i;
  logic [ADDR_WIDTH-1:0] write1_addr_i;
  logic [DATA_WIDTH-1:0] data1_i;
  logic                  write2_en_i;
  logic [ADDR_WIDTH-1:0] write2_addr_i;
  logic [DATA_WIDTH-1:0] data2_i;
  logic                  read1_en_i;
  logic [ADDR_WIDTH-1:0] read1_addr_i;
  logic                  read2_en_i;
  logic [ADDR_WIDTH-1:0] read2_addr_i;
  logic [DATA_WIDTH-1:0] data1_o;
  logic                  valid1_o;
  logic [DATA_WIDTH-1:0] data2_o;
  logic                  valid2_o;
  logic [CNT_WIDTH-1:0]  conflict_cnt_o;

  modport master (
    output clear_i,
    output write1_en_i, write1_addr_i, data1_i,
    output write2_en_i, write2_addr_i, data2_i,
    output read1_en_i, read1_addr_i,
    output read2_en_i, read2_addr_i,
    input  data1_o, valid1_o, data2_o, valid2_o, conflict_cnt_o
  );

  modport slave (
    input  clear_i,
    input  write1_en_i, write1_addr_i, data1_i,
    input  write2_en_i, write2_addr_i, data2_i,
    input  read1_en_i, read1_addr_i,
    input  read2_en_i, read2_addr_i,
    output data1_o, valid1_o, data2_o, valid2_o, conflict_cnt_o
  );
endinterface

// File: rtl/rf_2r_2w_bypass.sv
// ---------------------------------------------------------------------------
// rf_2r_2w_bypass
//   DEPTH-entry register file with two synchronous write ports, two
//   registered read ports, per-entry valid bits, port-1 write priority on
//   address collisions, optional same-cycle write-to-read forwarding, bulk
//   clear and a saturating counter of dropped port-2 writes.
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (overrides every other input)
//   bus   rf_2r_2w_bypass_if.slave -- write/read/clear requests in,
//         registered read data/valid and conflict count out
// Parameters
//   DATA_WIDTH  entry width
//   DEPTH       number of entries (>= 2, any value)
//   BYPASS      1: reads see same-cycle write data; 0: reads see old contents
//   CNT_WIDTH   conflict counter width
// ---------------------------------------------------------------------------
module rf_2r_2w_bypass #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int BYPASS     = 1,
  parameter int CNT_WIDTH  = 8
) (
  input logic               clk,
  input logic               rst,
  rf_2r_2w_bypass_if.slave  bus
);
  // Derived from DEPTH; kept local so it cannot drift from the entry count.
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } rd_t;

  // DEPTH need not be a power of two, so some encodable addresses are holes.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  rd_t                   rd_q    [2];
  rd_t                   rd_d    [2];
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;

  logic                  rd_en   [2];
  logic [ADDR_WIDTH-1:0] rd_addr [2];

  logic w1_ok, w2_ok, conflict, w1_eff, w2_eff;

  assign rd_en[0]   = bus.read1_en_i;
  assign rd_en[1]   = bus.read2_en_i;
  assign rd_addr[0] = bus.read1_addr_i;
  assign rd_addr[1] = bus.read2_addr_i;

  // A write is a candidate only when addressed in range and no clear is
  // pending; clear discards writes, so they can neither land nor conflict.
  assign w1_ok    = bus.write1_en_i && in_range(bus.write1_addr_i) && !bus.clear_i;
  assign w2_ok    = bus.write2_en_i && in_range(bus.write2_addr_i) && !bus.clear_i;
  assign conflict = w1_ok && w2_ok && (bus.write1_addr_i == bus.write2_addr_i);
  assign w1_eff   = w1_ok;
  assign w2_eff   = w2_ok && !conflict;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (conflict && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Read next-state: old contents, optionally overridden by a same-cycle
  // effective write (port 1 wins when both target the read address).
  // NOTE: combinational logic uses blocking '='; state in always_ff uses '<='.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_d[p] = '0;
      if (rd_en[p] && in_range(rd_addr[p])) begin
        rd_d[p].data  = mem_q[rd_addr[p]];
        rd_d[p].valid = valid_q[rd_addr[p]];
        if (BYPASS != 0) begin
          if (w1_eff && (bus.write1_addr_i == rd_addr[p])) begin
            rd_d[p].data  = bus.data1_i;
            rd_d[p].valid = 1'b1;
          end else if (w2_eff && (bus.write2_addr_i == rd_addr[p])) begin
            rd_d[p].data  = bus.data2_i;
            rd_d[p].valid = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the storage array is reset explicitly because the block must come
  // out of reset with every entry reading back as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q <= '0;
      rd_q[0] <= '0;
      rd_q[1] <= '0;
      cnt_q   <= '0;
    end else begin
      rd_q[0] <= rd_d[0];
      rd_q[1] <= rd_d[1];
      cnt_q   <= cnt_d;
      if (bus.clear_i) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        valid_q <= '0;
      end else begin
        if (w1_eff) begin
          mem_q[bus.write1_addr_i]   <= bus.data1_i;
          valid_q[bus.write1_addr_i] <= 1'b1;
        end
        if (w2_eff) begin
          mem_q[bus.write2_addr_i]   <= bus.data2_i;
          valid_q[bus.write2_addr_i] <= 1'b1;
        end
      end
    end
  end

  assign bus.data1_o        = rd_q[0].data;
  assign bus.valid1_o       = rd_q[0].valid;
  assign bus.data2_o        = rd_q[1].data;
  assign bus.valid2_o       = rd_q[1].valid;
  assign bus.conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_rf_2r_2w_bypass.sv
// ---------------------------------------------------------------------------
// tb_rf_2r_2w_bypass
//   Drives three register-file instances with identical stimulus:
//     dut 0: DEPTH 8, BYPASS 1   dut 1: DEPTH 8, BYPASS 0   dut 2: DEPTH 6, BYPASS 1
//   Directed scenarios check against constants; randomized traffic is checked
//   against a per-instance behavioural model kept as plain arrays.
// ---------------------------------------------------------------------------
module tb_rf_2r_2w_bypass;
  localparam int DW   = 32;
  localparam int AW   = 3;
  localparam int CW   = 8;
  localparam int NDUT = 3;
  localparam int CFG_DEPTH [NDUT] = '{8, 8, 6};
  localparam int CFG_BP    [NDUT] = '{1, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic w1_en = 1'b0, w2_en = 1'b0, r1_en = 1'b0, r2_en = 1'b0;
  logic [AW-1:0] w1_addr = '0, w2_addr = '0, r1_addr = '0, r2_addr = '0;
  logic [DW-1:0] wd1 = '0, wd2 = '0;

  logic [DW-1:0] o_d   [NDUT][2];
  logic          o_v   [NDUT][2];
  logic [CW-1:0] o_cnt [NDUT];

  // Behavioural model state
  logic [DW-1:0] m_mem [NDUT][8];
  logic          m_val [NDUT][8];
  logic [DW-1:0] m_d   [NDUT][2];
  logic          m_v   [NDUT][2];
  int            m_cnt [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    rf_2r_2w_bypass_if #(.DATA_WIDTH(DW), .DEPTH(CFG_DEPTH[g]), .CNT_WIDTH(CW)) bus_if ();
    assign bus_if.clear_i       = clear;
    assign bus_if.write1_en_i   = w1_en;
    assign bus_if.write1_addr_i = w1_addr;
    assign bus_if.data1_i       = wd1;
    assign bus_if.write2_en_i   = w2_en;
    assign bus_if.write2_addr_i = w2_addr;
    assign bus_if.data2_i       = wd2;
    assign bus_if.read1_en_i    = r1_en;
    assign bus_if.read1_addr_i  = r1_addr;
    assign bus_if.read2_en_i    = r2_en;
    assign bus_if.read2_addr_i  = r2_addr;

    rf_2r_2w_bypass #(
      .DATA_WIDTH(DW), .DEPTH(CFG_DEPTH[g]), .BYPASS(CFG_BP[g]), .CNT_WIDTH(CW)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
    );

    assign o_d[g][0] = bus_if.data1_o;
    assign o_v[g][0] = bus_if.valid1_o;
    assign o_d[g][1] = bus_if.data2_o;
    assign o_v[g][1] = bus_if.valid2_o;
    assign o_cnt[g]  = bus_if.conflict_cnt_o;
  end

  // Reference model: apply the rules for one clock edge using the current inputs.
  task automatic model_step();
    logic          w_ok [2];
    logic [AW-1:0] wa [2];
    logic [DW-1:0] wdat [2];
    logic          re [2];
    logic [AW-1:0] ra [2];
    logic          conf;
    wa   = '{w1_addr, w2_addr};
    wdat = '{wd1, wd2};
    re   = '{r1_en, r2_en};
    ra   = '{r1_addr, r2_addr};
    for (int c = 0; c < NDUT; c++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) begin m_mem[c][i] = '0; m_val[c][i] = 1'b0; end
        for (int p = 0; p < 2; p++) begin m_d[c][p] = '0; m_v[c][p] = 1'b0; end
        m_cnt[c] = 0;
      end else begin
        w_ok[0] = w1_en && (int'(w1_addr) < CFG_DEPTH[c]) && !clear;
        w_ok[1] = w2_en && (int'(w2_addr) < CFG_DEPTH[c]) && !clear;
        conf    = w_ok[0] && w_ok[1] && (w1_addr == w2_addr);
        if (conf) w_ok[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          if (!re[p] || int'(ra[p]) >= CFG_DEPTH[c]) begin
            m_d[c][p] = '0; m_v[c][p] = 1'b0;
          end else if (CFG_BP[c] == 1 && w_ok[0] && wa[0] == ra[p]) begin
            m_d[c][p] = wdat[0]; m_v[c][p] = 1'b1;
          end else if (CFG_BP[c] == 1 && w_ok[1] && wa[1] == ra[p]) begin
            m_d[c][p] = wdat[1]; m_v[c][p] = 1'b1;
          end else begin
            m_d[c][p] = m_mem[c][ra[p]]; m_v[c][p] = m_val[c][ra[p]];
          end
        end
        if (clear) begin
          for (int i = 0; i < 8; i++) begin m_mem[c][i] = '0; m_val[c][i] = 1'b0; end
        end else begin
          for (int q = 0; q < 2; q++)
            if (w_ok[q]) begin m_mem[c][wa[q]] = wdat[q]; m_val[c][wa[q]] = 1'b1; end
        end
        if (conf && m_cnt[c] < 255) m_cnt[c]++;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; w1_en = 1'b0; w2_en = 1'b0; r1_en = 1'b0; r2_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    cycle(); cycle();
    rst = 1'b0;
    r1_en = 1'b1; r1_addr = 3'd3;
    cycle();
    idle();
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (o_d[c][0] !== '0 || o_v[c][0] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read dut%0d: got %h/%b expected 0/0", c, o_d[c][0], o_v[c][0]);
      end
      n_checks++;
      if (o_cnt[c] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_cnt dut%0d: got %0d expected 0", c, o_cnt[c]);
      end
    end
  endtask

  task automatic test_dual_write();
    w1_en = 1'b1; w1_addr = 3'd2; wd1 = 32'hA5A5_0001;
    w2_en = 1'b1; w2_addr = 3'd5; wd2 = 32'h0000_BEEF;
    cycle();
    idle();
    r1_en = 1'b1; r1_addr = 3'd2; r2_en = 1'b1; r2_addr = 3'd5;
    cycle();
    idle();
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (o_d[c][0] !== 32'hA5A5_0001 || o_v[c][0] !== 1'b1 ||
          o_d[c][1] !== 32'h0000_BEEF || o_v[c][1] !== 1'b1 || o_cnt[c] !== 8'd0) begin
        n_fail++;
        $display("FAIL dual_write dut%0d: got %h/%b %h/%b cnt %0d expected a5a50001/1 0000beef/1 cnt 0",
                 c, o_d[c][0], o_v[c][0], o_d[c][1], o_v[c][1], o_cnt[c]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_d [NDUT];
    logic          exp_v [NDUT];
    // Single writer into never-written entry 6 while both ports read it.
    w1_en = 1'b1; w1_addr = 3'd6; wd1 = 32'h77;
    r1_en = 1'b1; r1_addr = 3'd6; r2_en = 1'b1; r2_addr = 3'd6;
    cycle();
    idle();
    exp_d = '{32'h77, 32'h0, 32'h0};
    exp_v = '{1'b1, 1'b0, 1'b0};
    for (int c = 0; c < NDUT; c++)
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (o_d[c][p] !== exp_d[c] || o_v[c][p] !== exp_v[c]) begin
          n_fail++;
          $display("FAIL bypass_single dut%0d port%0d: got %h/%b expected %h/%b",
                   c, p, o_d[c][p], o_v[c][p], exp_d[c], exp_v[c]);
        end
      end
    // Both writers collide on never-written entry 3: port-1 data is forwarded.
    w1_en = 1'b1; w1_addr = 3'd3; wd1 = 32'hAA;
    w2_en = 1'b1; w2_addr = 3'd3; wd2 = 32'hBB;
    r1_en = 1'b1; r1_addr = 3'd3;
    cycle();
    idle();
    exp_d = '{32'hAA, 32'h0, 32'hAA};
    exp_v = '{1'b1, 1'b0, 1'b1};
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (o_d[c][0] !== exp_d[c] || o_v[c][0] !== exp_v[c] || o_cnt[c] !== 8'd1) begin
        n_fail++;
        $display("FAIL bypass_dual dut%0d: got %h/%b cnt %0d expected %h/%b cnt 1",
                 c, o_d[c][0], o_v[c][0], o_cnt[c], exp_d[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] exp_d [NDUT];
    logic          exp_v [NDUT];
    int            exp_c [NDUT];
    // Collision on address 7: a real conflict for DEPTH 8, ignored for DEPTH 6.
    w1_en = 1'b1; w1_addr = 3'd7; wd1 = 32'h5;
    w2_en = 1'b1; w2_addr = 3'd7; wd2 = 32'h6;
    cycle();
    idle();
    r1_en = 1'b1; r1_addr = 3'd7; r2_en = 1'b1; r2_addr = 3'd7;
    cycle();
    idle();
    exp_d = '{32'h5, 32'h5, 32'h0};
    exp_v = '{1'b1, 1'b1, 1'b0};
    exp_c = '{2, 2, 1};
    for (int c = 0; c < NDUT; c++) begin
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (o_d[c][p] !== exp_d[c] || o_v[c][p] !== exp_v[c]) begin
          n_fail++;
          $display("FAIL oor_read dut%0d port%0d: got %h/%b expected %h/%b",
                   c, p, o_d[c][p], o_v[c][p], exp_d[c], exp_v[c]);
        end
      end
      n_checks++;
      if (int'(o_cnt[c]) != exp_c[c]) begin
        n_fail++;
        $display("FAIL oor_cnt dut%0d: got %0d expected %0d", c, o_cnt[c], exp_c[c]);
      end
    end
  endtask

  task automatic test_conflict();
    int exp_c [NDUT];
    w1_en = 1'b1; w1_addr = 3'd4; wd1 = 32'h11;
    w2_en = 1'b1; w2_addr = 3'd4; wd2 = 32'h22;
    cycle();
    idle();
    r1_en = 1'b1; r1_addr = 3'd4;
    cycle();
    idle();
    exp_c = '{3, 3, 2};
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (o_d[c][0] !== 32'h11 || o_v[c][0] !== 1'b1 || int'(o_cnt[c]) != exp_c[c]) begin
        n_fail++;
        $display("FAIL conflict_once dut%0d: got %h/%b cnt %0d expected 00000011/1 cnt %0d",
                 c, o_d[c][0], o_v[c][0], o_cnt[c], exp_c[c]);
      end
    end
    for (int k = 0; k < 300; k++) begin
      w1_en = 1'b1; w2_en = 1'b1;
      w1_addr = 3'($urandom_range(0, 5)); w2_addr = w1_addr;
      wd1 = $urandom; wd2 = $urandom;
      cycle();
    end
    idle();
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (o_cnt[c] !== 8'd255) begin
        n_fail++;
        $display("FAIL conflict_saturate dut%0d: got %0d expected 255", c, o_cnt[c]);
      end
    end
  endtask

  task automatic test_clear();
    logic [DW-1:0] fill [8];
    for (int i = 0; i < 8; i++) fill[i] = $urandom | 32'h1;
    for (int i = 0; i < 4; i++) begin
      w1_en = 1'b1; w1_addr = 3'(2 * i);     wd1 = fill[2 * i];
      w2_en = 1'b1; w2_addr = 3'(2 * i + 1); wd2 = fill[2 * i + 1];
      cycle();
    end
    idle();
    clear = 1'b1;
    w1_en = 1'b1; w1_addr = 3'd1; wd1 = 32'h99;
    r1_en = 1'b1; r1_addr = 3'd0; r2_en = 1'b1; r2_addr = 3'd1;
    cycle();
    idle();
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (o_d[c][0] !== fill[0] || o_v[c][0] !== 1'b1 ||
          o_d[c][1] !== fill[1] || o_v[c][1] !== 1'b1) begin
        n_fail++;
        $display("FAIL clear_same_cycle dut%0d: got %h/%b %h/%b expected %h/1 %h/1",
                 c, o_d[c][0], o_v[c][0], o_d[c][1], o_v[c][1], fill[0], fill[1]);
      end
    end
    for (int a = 0; a < 8; a++) begin
      r1_en = 1'b1; r1_addr = 3'(a); r2_en = 1'b1; r2_addr = 3'(7 - a);
      cycle();
      for (int c = 0; c < NDUT; c++)
        for (int p = 0; p < 2; p++) begin
          n_checks++;
          if (o_d[c][p] !== '0 || o_v[c][p] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_after dut%0d port%0d addr%0d: got %h/%b expected 0/0",
                     c, p, (p == 0) ? a : 7 - a, o_d[c][p], o_v[c][p]);
          end
        end
    end
    idle();
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (o_cnt[c] !== 8'd255) begin
        n_fail++;
        $display("FAIL clear_cnt dut%0d: got %0d expected 255", c, o_cnt[c]);
      end
    end
  endtask

  task automatic test_random();
    rst = 1'b1; idle();
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 600; k++) begin
      rst     = ($urandom_range(0, 63) == 0);
      clear   = ($urandom_range(0, 15) == 0);
      w1_en   = $urandom_range(0, 1);
      w2_en   = $urandom_range(0, 1);
      r1_en   = ($urandom_range(0, 3) != 0);
      r2_en   = ($urandom_range(0, 3) != 0);
      w1_addr = 3'($urandom_range(0, 7));
      w2_addr = ($urandom_range(0, 2) == 0) ? w1_addr : 3'($urandom_range(0, 7));
      r1_addr = ($urandom_range(0, 2) == 0) ? w1_addr : 3'($urandom_range(0, 7));
      r2_addr = ($urandom_range(0, 2) == 0) ? w2_addr : 3'($urandom_range(0, 7));
      wd1     = $urandom;
      wd2     = $urandom;
      cycle();
      for (int c = 0; c < NDUT; c++) begin
        for (int p = 0; p < 2; p++) begin
          n_checks++;
          if (o_d[c][p] !== m_d[c][p] || o_v[c][p] !== m_v[c][p]) begin
            n_fail++;
            $display("FAIL random_read cyc%0d dut%0d port%0d: got %h/%b expected %h/%b",
                     k, c, p, o_d[c][p], o_v[c][p], m_d[c][p], m_v[c][p]);
          end
        end
        n_checks++;
        if (int'(o_cnt[c]) != m_cnt[c]) begin
          n_fail++;
          $display("FAIL random_cnt cyc%0d dut%0d: got %0d expected %0d", k, c, o_cnt[c], m_cnt[c]);
        end
      end
    end
    rst = 1'b0; idle();
  endtask

  task automatic test_reset_mid();
    // Make the counter and an entry non-zero first so reset has work to do.
    w1_en = 1'b1; w1_addr = 3'd2; wd1 = 32'hCAFE;
    w2_en = 1'b1; w2_addr = 3'd2; wd2 = 32'hF00D;
    r1_en = 1'b1; r1_addr = 3'd2;
    cycle();
    rst = 1'b1;
    w2_en = 1'b0;
    w1_addr = 3'd4; wd1 = 32'h1234; r2_en = 1'b1; r2_addr = 3'd2;
    cycle();
    rst = 1'b0; idle();
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (o_d[c][0] !== '0 || o_v[c][0] !== 1'b0 || o_d[c][1] !== '0 ||
          o_v[c][1] !== 1'b0 || o_cnt[c] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_mid_outputs dut%0d: got %h/%b %h/%b cnt %0d expected all 0",
                 c, o_d[c][0], o_v[c][0], o_d[c][1], o_v[c][1], o_cnt[c]);
      end
    end
    r1_en = 1'b1; r1_addr = 3'd4; r2_en = 1'b1; r2_addr = 3'd2;
    cycle();
    idle();
    for (int c = 0; c < NDUT; c++)
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (o_d[c][p] !== '0 || o_v[c][p] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid_contents dut%0d port%0d: got %h/%b expected 0/0",
                   c, p, o_d[c][p], o_v[c][p]);
        end
      end
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_bypass();
    test_out_of_range();
    test_conflict();
    test_clear();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
